// File: rtl/sram_pkg.sv
// Shared types, parameter helpers and elaboration checks for the masked-write SRAM model.
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_state_e;

    // Minimum of one address bit so a single-word memory still has a port.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic bit gran_ok(input int width, input int gran);
        return (gran > 0) && ((width % gran) == 0);
    endfunction

endpackage

// File: rtl/sram_rw_masked_init_if.sv
// Single read/write access port of the SRAM model.
// Handshake: an access is taken on a rising edge when en and ready are both 1;
// nothing is held or retried, so an access offered while ready is 0 is simply lost.
// Read results come back as a one-cycle rvalid strobe with rdata held until the next one.
interface sram_rw_masked_init_if #(
    parameter int ADDR_W = 9,
    parameter int WIDTH  = 16,
    parameter int MASK_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              wmode;
    logic [MASK_W-1:0] wmask;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;
    logic              ready;

    modport master (
        output addr, en, wmode, wmask, wdata,
        input  rdata, rvalid, ready
    );

    modport slave (
        input  addr, en, wmode, wmask, wdata,
        output rdata, rvalid, ready
    );
endinterface

// File: rtl/sram_init_seq.sv
// Post-reset fill sequencer: walks every address once with a write enable, then opens the port.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter bit INIT_EN = 1'b1,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              ready,
    output sram_state_e       state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sram_state_e       state, state_next;
    logic [ADDR_W-1:0] count, count_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_EN ? INIT : RUN;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        init_we    = 1'b0;
        ready      = 1'b0;
        case (state)
            INIT: begin
                init_we = 1'b1;
                if (count == LAST_ADDR) begin
                    state_next = RUN;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign init_addr = count;
    assign state_dbg = state;

endmodule

// File: rtl/sram_rw_masked_init.sv
// Parametrised single-port bit-masked SRAM with selectable read latency and a post-reset fill.
module sram_rw_masked_init
    import sram_pkg::*;
#(
    parameter int               DEPTH        = 512,
    parameter int               WIDTH        = 16,
    parameter int               MASK_GRAN    = 2,
    parameter int               READ_LATENCY = 1,
    parameter bit               INIT_EN      = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  RW0_clk,
    input  logic                  RW0_rst_n,
    sram_rw_masked_init_if.slave  rw0,
    output sram_state_e           dbg_state
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int MASK_W = WIDTH / MASK_GRAN;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (!gran_ok(WIDTH, MASK_GRAN)) begin : g_bad_gran
        $error("WIDTH must be a multiple of MASK_GRAN");
    end

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              ready;

    sram_init_seq #(
        .DEPTH   (DEPTH),
        .INIT_EN (INIT_EN),
        .ADDR_W  (ADDR_W)
    ) u_init_seq (
        .clk       (RW0_clk),
        .rst_n     (RW0_rst_n),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready),
        .state_dbg (dbg_state)
    );

    logic [WIDTH-1:0] mem [DEPTH];

    logic             in_range;
    logic             accept;
    logic             user_we;
    logic             read_acc;
    logic [WIDTH-1:0] cur_word;
    logic [WIDTH-1:0] merged;

    assign in_range = {1'b0, rw0.addr} < DEPTH_L;
    assign accept   = rw0.en & ready & RW0_rst_n;
    assign user_we  = accept & rw0.wmode & in_range;
    assign read_acc = accept & ~rw0.wmode;

    // Out-of-range reads see zero; the same word feeds the lane merge for writes.
    always_comb begin
        cur_word = '0;
        if (in_range) cur_word = mem[rw0.addr];
        merged = cur_word;
        for (int i = 0; i < MASK_W; i++) begin
            if (rw0.wmask[i]) merged[i*MASK_GRAN +: MASK_GRAN] = rw0.wdata[i*MASK_GRAN +: MASK_GRAN];
        end
    end

    // Array has no reset: only the sweep defines its contents.
    always_ff @(posedge RW0_clk) begin
        if (init_we) begin
            mem[init_addr] <= INIT_VALUE;
        end else if (user_we) begin
            mem[rw0.addr] <= merged;
        end
    end

    logic             s0_valid;
    logic [WIDTH-1:0] s0_data;
    logic             pre_valid;
    logic [WIDTH-1:0] pre_data;
    logic             rvalid_q;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
        end else begin
            s0_valid <= read_acc;
            if (read_acc) s0_data <= cur_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic             s1_valid;
        logic [WIDTH-1:0] s1_data;

        always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
            if (!RW0_rst_n) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
            end else begin
                s1_valid <= s0_valid;
                if (s0_valid) s1_data <= s0_data;
            end
        end

        assign pre_valid = s1_valid;
        assign pre_data  = s1_data;
    end else begin : g_lat1
        assign pre_valid = s0_valid;
        assign pre_data  = s0_data;
    end

    // Output register only loads on a returning read, so rdata holds between strobes.
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pre_valid;
            if (pre_valid) rdata_q <= pre_data;
        end
    end

    assign rw0.rdata  = rdata_q;
    assign rw0.rvalid = rvalid_q;
    assign rw0.ready  = ready;

endmodule

// File: tb/tb_sram_rw_masked_init.sv
// Directed bench for the masked SRAM: latency-1 instance (fill 0xA5A5) and latency-2 instance (fill 0).
module tb_sram_rw_masked_init;
    import sram_pkg::*;

    localparam int DEPTH = 300;
    localparam int WIDTH = 16;
    localparam int GRAN  = 2;
    localparam int AW    = clog2(DEPTH);
    localparam int MW    = WIDTH / GRAN;
    localparam logic [15:0] IV_A = 16'hA5A5;
    localparam logic [15:0] IV_B = 16'h0000;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    sram_rw_masked_init_if #(.ADDR_W(AW), .WIDTH(WIDTH), .MASK_W(MW)) ifa ();
    sram_rw_masked_init_if #(.ADDR_W(AW), .WIDTH(WIDTH), .MASK_W(MW)) ifb ();
    sram_state_e st_a, st_b;

    sram_rw_masked_init #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(GRAN),
        .READ_LATENCY(1), .INIT_EN(1'b1), .INIT_VALUE(IV_A)
    ) dut_a (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .rw0(ifa), .dbg_state(st_a)
    );

    sram_rw_masked_init #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(GRAN),
        .READ_LATENCY(2), .INIT_EN(1'b1), .INIT_VALUE(IV_B)
    ) dut_b (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .rw0(ifb), .dbg_state(st_b)
    );

    // scoreboard
    logic [WIDTH-1:0] exp_a[$], exp_b[$];
    int               due_a[$], due_b[$];
    logic [WIDTH-1:0] model_a[DEPTH], model_b[DEPTH];
    logic [WIDTH-1:0] mon_e_a, mon_e_b;
    int               mon_d_a, mon_d_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] data,
                                          input logic [7:0] mask);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) r[2*i +: 2] = data[2*i +: 2];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (ifa.rvalid === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_rvalid", 32'(exp_a.size() > 0), 32'd1);
            end else begin
                mon_e_a = exp_a.pop_front();
                mon_d_a = due_a.pop_front();
                check("a_rdata", 32'(ifa.rdata), 32'(mon_e_a));
                check("a_latency", cyc, mon_d_a);
            end
        end
        if (ifb.rvalid === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_rvalid", 32'(exp_b.size() > 0), 32'd1);
            end else begin
                mon_e_b = exp_b.pop_front();
                mon_d_b = due_b.pop_front();
                check("b_rdata", 32'(ifb.rdata), 32'(mon_e_b));
                check("b_latency", cyc, mon_d_b);
            end
        end
    end

    // driver tasks
    task automatic idle_all();
        ifa.en = 1'b0; ifa.wmode = 1'b0; ifa.addr = '0; ifa.wmask = '0; ifa.wdata = '0;
        ifb.en = 1'b0; ifb.wmode = 1'b0; ifb.addr = '0; ifb.wmask = '0; ifb.wdata = '0;
    endtask

    // sel 0 drives port A, 1 drives port B; live means the port is expected to accept.
    task automatic step(input bit sel, input bit en, input bit wm, input int addr,
                        input logic [7:0] mask, input logic [15:0] data, input bit live);
        logic [15:0] e;
        @(negedge clk);
        idle_all();
        if (!sel) begin
            ifa.en = en; ifa.wmode = wm; ifa.addr = AW'(addr); ifa.wmask = mask; ifa.wdata = data;
        end else begin
            ifb.en = en; ifb.wmode = wm; ifb.addr = AW'(addr); ifb.wmask = mask; ifb.wdata = data;
        end
        if (live && en) begin
            if (wm) begin
                if (addr < DEPTH) begin
                    if (!sel) model_a[addr] = merge(model_a[addr], data, mask);
                    else      model_b[addr] = merge(model_b[addr], data, mask);
                end
            end else begin
                e = '0;
                if (addr < DEPTH) e = sel ? model_b[addr] : model_a[addr];
                if (!sel) begin exp_a.push_back(e); due_a.push_back(cyc + 2); end
                else      begin exp_b.push_back(e); due_b.push_back(cyc + 3); end
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && (exp_a.size() + exp_b.size()) > 0; k++) begin
            @(negedge clk);
            #1;
        end
        check("drain", 32'(exp_a.size() + exp_b.size()), 32'd0);
    endtask

    // Called right after reset release; k counts rising edges since release.
    task automatic init_phase(input bit drop);
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            idle_all();
            if (drop && k <= 50) begin
                ifa.en = 1'b1; ifa.wmode = 1'b1; ifa.addr = AW'(100); ifa.wmask = '1; ifa.wdata = 16'h5555;
                ifb.en = 1'b1; ifb.wmode = 1'b0; ifb.addr = AW'(5);
            end
            if (k == DEPTH - 1) begin
                check("a_ready_before_done", 32'(ifa.ready), 32'd0);
                check("b_ready_before_done", 32'(ifb.ready), 32'd0);
            end
            if (k == DEPTH) begin
                check("a_ready_done", 32'(ifa.ready), 32'd1);
                check("b_ready_done", 32'(ifb.ready), 32'd1);
                check("a_state_run", 32'(st_a), 32'(RUN));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            model_a[i] = IV_A;
            model_b[i] = IV_B;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("a_rst_rvalid", 32'(ifa.rvalid), 32'd0);
        check("a_rst_rdata", 32'(ifa.rdata), 32'd0);
        check("a_rst_ready", 32'(ifa.ready), 32'd0);
        check("b_rst_rvalid", 32'(ifb.rvalid), 32'd0);
        check("b_rst_rdata", 32'(ifb.rdata), 32'd0);
        check("b_rst_ready", 32'(ifb.ready), 32'd0);
        check("a_rst_state", 32'(st_a), 32'(INIT));

        // abort the sweep part-way, then let a full sweep run with dropped accesses
        @(negedge clk); rst_n = 1'b1;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("a_midsweep_ready", 32'(ifa.ready), 32'd0);
        check("a_midsweep_rvalid", 32'(ifa.rvalid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        init_phase(1'b1);

        // sweep contents, dropped write, out-of-range
        step(0, 1, 0, 0,   8'h00, 16'h0000, 1);
        step(0, 1, 0, 150, 8'h00, 16'h0000, 1);
        step(0, 1, 0, 299, 8'h00, 16'h0000, 1);
        step(0, 1, 0, 100, 8'h00, 16'h0000, 1);
        step(0, 1, 0, 310, 8'h00, 16'h0000, 1);
        step(0, 1, 1, 310, 8'hFF, 16'h0000, 1);
        step(0, 1, 0, 310, 8'h00, 16'h0000, 1);
        step(0, 1, 0, 54,  8'h00, 16'h0000, 1);
        step(0, 1, 0, 299, 8'h00, 16'h0000, 1);
        step(0, 0, 0, 0,   8'h00, 16'h0000, 1);
        drain();

        // write then immediate read of the same word
        step(0, 1, 1, 20, 8'hFF, 16'h1357, 1);
        step(0, 1, 0, 20, 8'h00, 16'h0000, 1);
        step(0, 0, 0, 0,  8'h00, 16'h0000, 1);
        drain();

        // random back-to-back masked traffic on a small address window
        for (int n = 0; n < 40; n++) begin
            step(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 1);
        end
        step(0, 0, 0, 0, 8'h00, 16'h0000, 1);
        drain();

        // latency-2 port: masked write, read-before-write ordering, held output
        step(1, 1, 1, 3, 8'h05, 16'hFFFF, 1);
        step(1, 1, 0, 3, 8'h00, 16'h0000, 1);
        step(1, 1, 1, 7, 8'hFF, 16'h1234, 1);
        step(1, 1, 0, 7, 8'h00, 16'h0000, 1);
        step(1, 1, 1, 7, 8'hFF, 16'hBEEF, 1);
        step(1, 0, 0, 0, 8'h00, 16'h0000, 1);
        drain();
        repeat (3) @(negedge clk);
        #1;
        check("b_rdata_held", 32'(ifb.rdata), 32'h1234);
        check("b_rvalid_idle", 32'(ifb.rvalid), 32'd0);
        step(1, 1, 0, 7, 8'h00, 16'h0000, 1);
        step(1, 0, 0, 0, 8'h00, 16'h0000, 1);
        drain();

        // reset while a read result is on the output
        step(0, 1, 0, 20, 8'h00, 16'h0000, 1);
        step(0, 0, 0, 0,  8'h00, 16'h0000, 1);
        @(posedge clk);
        #2;
        check("a_rvalid_before_reset", 32'(ifa.rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("a_rvalid_reset_drop", 32'(ifa.rvalid), 32'd0);
        check("a_ready_reset_drop", 32'(ifa.ready), 32'd0);
        check("b_ready_reset_drop", 32'(ifb.ready), 32'd0);
        exp_a.delete(); due_a.delete();
        exp_b.delete(); due_b.delete();
        @(negedge clk); rst_n = 1'b1;
        init_phase(1'b0);

        // sweep has refilled previously written words
        step(0, 1, 0, 20, 8'h00, 16'h0000, 1);
        step(1, 1, 0, 3,  8'h00, 16'h0000, 1);
        step(1, 1, 0, 7,  8'h00, 16'h0000, 1);
        step(1, 0, 0, 0,  8'h00, 16'h0000, 1);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
